camera_dvp_tx: RTL and testbench

CAMERA_DVP_TX -- requirements
Module: camera_dvp_tx

---
 rtl/camera_dvp_tx.sv | 188 ++++++++++++++++++
 tb/tb_camera_dvp_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_dvp_tx.sv
// DVP camera transmitter: reads 32-bit frame-buffer words and serialises them as a VSYNC/HREF/PCLK byte stream.
// Define CAMERA_TX_BGR_SWAP_EN to exchange the red and blue fields of each RGB565 pixel before sending.
module camera_dvp_tx #(
    parameter int H_PIX     = 320,
    parameter int V_LINES   = 240,
    parameter int VSYNC_LEN = 3,
    parameter int V_BP      = 2,
    parameter int H_BLANK   = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        START,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [15:0] RAM_RADDR,
    input  logic [31:0] RAM_RDATA,
    output logic        PCLK_OUT,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  Camera_odata,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        VS   = 3'd1,
        VBP  = 3'd2,
        LINE = 3'd3,
        HBL  = 3'd4
    } state_t;

    localparam logic [15:0] LINE_LAST  = 16'(2 * H_PIX + H_BLANK - 1);
    localparam logic [15:0] ACT_LAST   = 16'(2 * H_PIX - 1);
    localparam logic [15:0] HBL_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] VS_LAST    = 16'(VSYNC_LEN - 1);
    localparam logic [15:0] VBP_LAST   = 16'(V_BP - 1);
    localparam logic [15:0] LINES_LAST = 16'(V_LINES - 1);
    localparam logic [15:0] ADDR_LAST  = 16'(H_PIX * V_LINES / 2 - 1);

    state_t      state;
    logic [15:0] slot_cnt;
    logic [15:0] line_cnt;
    logic [31:0] word_q;
    logic [1:0]  byte_idx;
    logic [31:0] byte_src;
    logic [7:0]  next_byte;
    logic [15:0] next_addr;

    function automatic logic [15:0] fmt_pix(input logic [15:0] p);
`ifdef CAMERA_TX_BGR_SWAP_EN
        return {p[4:0], p[10:5], p[15:11]};
`else
        return p;
`endif
    endfunction

    // Byte order inside a word: pixel 0 (low half) then pixel 1, each high byte first.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [15:0] p0;
        logic [15:0] p1;
        p0 = fmt_pix(w[15:0]);
        p1 = fmt_pix(w[31:16]);
        case (idx)
            2'd0:    return p0[15:8];
            2'd1:    return p0[7:0];
            2'd2:    return p1[15:8];
            default: return p1[7:0];
        endcase
    endfunction

    // Outside LINE the next slot is always the first byte of a fresh word, taken straight from RAM.
    always_comb begin
        byte_idx = 2'd0;
        if (state == LINE) begin
            byte_idx = slot_cnt[1:0] + 2'd1;
        end
        byte_src  = (byte_idx == 2'd0) ? RAM_RDATA : word_q;
        next_byte = pick_byte(byte_src, byte_idx);
        next_addr = (RAM_RADDR == ADDR_LAST) ? RAM_RADDR : RAM_RADDR + 16'd1;
    end

    assign state_dbg = state;

    // START is a request without a ready: it is taken only while BUSY is low, and BUSY
    // stays high through the FRAME_DONE cycle, so a request while busy or coincident with
    // FRAME_DONE is dropped. RAM_RADDR always points at the next word to be sent, so the
    // synchronous RAM has its data ready long before the slot that consumes it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            slot_cnt     <= 16'd0;
            line_cnt     <= 16'd0;
            word_q       <= 32'd0;
            BUSY         <= 1'b0;
            FRAME_DONE   <= 1'b0;
            RAM_RADDR    <= 16'd0;
            PCLK_OUT     <= 1'b0;
            VSYNC        <= 1'b0;
            HREF         <= 1'b0;
            Camera_odata <= 8'd0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (state == IDLE) begin
                PCLK_OUT <= 1'b0;
                if (START && !BUSY) begin
                    state     <= VS;
                    BUSY      <= 1'b1;
                    VSYNC     <= 1'b1;
                    RAM_RADDR <= 16'd0;
                    slot_cnt  <= 16'd0;
                    line_cnt  <= 16'd0;
                end else begin
                    BUSY <= 1'b0;
                end
            end else begin
                PCLK_OUT <= ~PCLK_OUT;
                // Everything else moves only at a slot boundary, i.e. as PCLK_OUT falls.
                if (PCLK_OUT) begin
                    slot_cnt <= slot_cnt + 16'd1;
                    case (state)
                        VS: begin
                            if (slot_cnt == LINE_LAST) begin
                                slot_cnt <= 16'd0;
                                if (line_cnt == VS_LAST) begin
                                    state    <= VBP;
                                    VSYNC    <= 1'b0;
                                    line_cnt <= 16'd0;
                                end else begin
                                    line_cnt <= line_cnt + 16'd1;
                                end
                            end
                        end
                        VBP: begin
                            if (slot_cnt == LINE_LAST) begin
                                slot_cnt <= 16'd0;
                                if (line_cnt == VBP_LAST) begin
                                    state        <= LINE;
                                    line_cnt     <= 16'd0;
                                    HREF         <= 1'b1;
                                    Camera_odata <= next_byte;
                                    word_q       <= RAM_RDATA;
                                    RAM_RADDR    <= next_addr;
                                end else begin
                                    line_cnt <= line_cnt + 16'd1;
                                end
                            end
                        end
                        LINE: begin
                            if (slot_cnt == ACT_LAST) begin
                                state        <= HBL;
                                slot_cnt     <= 16'd0;
                                HREF         <= 1'b0;
                                Camera_odata <= 8'd0;
                            end else begin
                                Camera_odata <= next_byte;
                                if (byte_idx == 2'd0) begin
                                    word_q    <= RAM_RDATA;
                                    RAM_RADDR <= next_addr;
                                end
                            end
                        end
                        HBL: begin
                            if (slot_cnt == HBL_LAST) begin
                                slot_cnt <= 16'd0;
                                if (line_cnt == LINES_LAST) begin
                                    state      <= IDLE;
                                    line_cnt   <= 16'd0;
                                    FRAME_DONE <= 1'b1;
                                end else begin
                                    state        <= LINE;
                                    line_cnt     <= line_cnt + 16'd1;
                                    HREF         <= 1'b1;
                                    Camera_odata <= next_byte;
                                    word_q       <= RAM_RDATA;
                                    RAM_RADDR    <= next_addr;
                                end
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_dvp_tx.sv
// Bench for camera_dvp_tx: random frame-buffer contents checked cycle by cycle against a frame-timing model.
// Build with CAMERA_TX_BGR_SWAP_EN defined to check the red/blue exchange variant.
module tb_camera_dvp_tx;
    localparam int H_PIX      = 6;
    localparam int V_LINES    = 3;
    localparam int VSYNC_LEN  = 2;
    localparam int V_BP       = 2;
    localparam int H_BLANK    = 3;
    localparam int LINE_SLOTS = 2 * H_PIX + H_BLANK;
    localparam int FRAME_CYC  = (VSYNC_LEN + V_BP + V_LINES) * LINE_SLOTS * 2;
    localparam int WORDS      = H_PIX * V_LINES / 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        START = 1'b0;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [15:0] RAM_RADDR;
    logic [31:0] RAM_RDATA = 32'd0;
    logic        PCLK_OUT;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  Camera_odata;
    logic [2:0]  state_dbg;

    logic [31:0] mem [64];
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    camera_dvp_tx #(
        .H_PIX(H_PIX), .V_LINES(V_LINES), .VSYNC_LEN(VSYNC_LEN), .V_BP(V_BP), .H_BLANK(H_BLANK)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .START(START), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
        .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA), .PCLK_OUT(PCLK_OUT), .VSYNC(VSYNC),
        .HREF(HREF), .Camera_odata(Camera_odata), .state_dbg(state_dbg)
    );

    // ---- clock / RAM / watchdog ----
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) RAM_RDATA <= mem[RAM_RADDR[5:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    // ---- reference model ----
    function automatic logic [15:0] ref_pixel(input logic [15:0] p);
`ifdef CAMERA_TX_BGR_SWAP_EN
        return {p[4:0], p[10:5], p[15:11]};
`else
        return p;
`endif
    endfunction

    // n-th active byte of the frame: word n/4, pixel 0 then pixel 1, high byte first
    function automatic logic [7:0] ref_byte(input int n);
        logic [31:0] w;
        logic [15:0] p;
        w = mem[n / 4];
        p = ((n % 4) < 2) ? ref_pixel(w[15:0]) : ref_pixel(w[31:16]);
        return ((n % 2) == 0) ? p[15:8] : p[7:0];
    endfunction

    // {BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF} in cycle k after the accepting edge
    function automatic logic [4:0] ref_ctrl(input int k);
        int s;
        int lp;
        int pos;
        if (k > FRAME_CYC) return 5'b00000;
        if (k == FRAME_CYC) return 5'b11000;
        s   = k / 2;
        lp  = s / LINE_SLOTS;
        pos = s % LINE_SLOTS;
        return {1'b1, 1'b0, 1'(k % 2), 1'(lp < VSYNC_LEN),
                1'((lp >= VSYNC_LEN + V_BP) && (pos < 2 * H_PIX))};
    endfunction

    // ---- scenario tasks ----
    task automatic run_frame(input string tag, input bit inject, input int tail);
        int          k_extra;
        logic [4:0]  exp_c;
        logic [4:0]  got_c;
        logic [7:0]  exp_d;
        logic [15:0] max_addr;
        exp_q.delete();
        obs_q.delete();
        for (int n = 0; n < WORDS * 4; n++) exp_q.push_back(ref_byte(n));
        k_extra  = $urandom_range(1, FRAME_CYC - 1);
        exp_d    = 8'd0;
        max_addr = 16'd0;
        START    = 1'b1;
        for (int k = 0; k <= FRAME_CYC + tail; k++) begin
            @(negedge HCLK);
            START = inject && (k == k_extra || k == FRAME_CYC);
            if (k == 0) begin
                n_checks++;
                if (RAM_RADDR !== 16'd0)
                    $display("FAIL %s first_addr got %0d want 0", tag, RAM_RADDR);
                else n_pass++;
            end
            if (RAM_RADDR > max_addr) max_addr = RAM_RADDR;
            exp_c = ref_ctrl(k);
            got_c = {BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF};
            n_checks++;
            if (got_c !== exp_c)
                $display("FAIL %s ctrl k=%0d got %b want %b (busy,done,pclk,vsync,href)", tag, k, got_c, exp_c);
            else n_pass++;
            if (!exp_c[0]) begin
                exp_d = 8'd0;
            end else if (!exp_c[2]) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd0;
                obs_q.push_back(Camera_odata);
            end
            n_checks++;
            if (Camera_odata !== exp_d)
                $display("FAIL %s data k=%0d got %h want %h", tag, k, Camera_odata, exp_d);
            else n_pass++;
        end
        START = 1'b0;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s bytes_left got %0d want 0", tag, exp_q.size());
        else n_pass++;
        n_checks++;
        if (max_addr !== 16'(WORDS - 1))
            $display("FAIL %s max_addr got %0d want %0d", tag, max_addr, WORDS - 1);
        else n_pass++;
        n_checks++;
        if (RAM_RADDR !== 16'(WORDS - 1))
            $display("FAIL %s end_addr got %0d want %0d", tag, RAM_RADDR, WORDS - 1);
        else n_pass++;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        START   = 1'b0;
        repeat (3) @(negedge HCLK);
        n_checks++;
        if ({BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR} !== 29'd0)
            $display("FAIL reset_values got %b want 0", {BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR});
        else n_pass++;
        HRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            n_checks++;
            if ({BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR} !== 29'd0)
                $display("FAIL idle_quiet i=%0d got %b want 0", i, {BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR});
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        logic [7:0] dir_exp [8];
`ifdef CAMERA_TX_BGR_SWAP_EN
        dir_exp = '{8'h00, 8'h1F, 8'h00, 8'h00, 8'h88, 8'hD8, 8'h80, 8'hB4};
`else
        dir_exp = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hD1, 8'hA0, 8'hB0};
`endif
        for (int n = 0; n < 64; n++) mem[n] = 32'hA0B0C0D0 + n;
        mem[0] = 32'h0000F800;
        run_frame("directed", 1'b0, 2);
        n_checks++;
        if (obs_q.size() != WORDS * 4)
            $display("FAIL directed_count got %0d want %0d", obs_q.size(), WORDS * 4);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_q.size() <= i || obs_q[i] !== dir_exp[i])
                $display("FAIL directed_byte%0d got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : 8'hxx, dir_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 64; n++) mem[n] = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge HCLK);
            run_frame("random", 1'b0, 2);
        end
    endtask

    task automatic test_start_while_busy();
        for (int n = 0; n < 64; n++) mem[n] = $urandom;
        run_frame("start_ignored", 1'b1, 8);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 64; n++) mem[n] = $urandom;
        run_frame("b2b_first", 1'b0, 1);
        run_frame("b2b_second", 1'b0, 2);
    endtask

    task automatic test_reset_midframe();
        int k_rst;
        for (int n = 0; n < 64; n++) mem[n] = $urandom;
        k_rst = 2 * ((VSYNC_LEN + V_BP + 1) * LINE_SLOTS + $urandom_range(0, 2 * H_PIX - 1))
                + $urandom_range(0, 1);
        START = 1'b1;
        for (int k = 0; k <= k_rst; k++) begin
            @(negedge HCLK);
            START = 1'b0;
        end
        n_checks++;
        if (HREF !== 1'b1)
            $display("FAIL midframe_in_line k=%0d got href=%b want 1", k_rst, HREF);
        else n_pass++;
        #2 HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR} !== 29'd0)
            $display("FAIL async_reset got %b want 0", {BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR});
        else n_pass++;
        @(negedge HCLK);
        n_checks++;
        if ({BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR} !== 29'd0)
            $display("FAIL held_reset got %b want 0", {BUSY, FRAME_DONE, PCLK_OUT, VSYNC, HREF, Camera_odata, RAM_RADDR});
        else n_pass++;
        HRESETn = 1'b1;
        @(negedge HCLK);
        for (int n = 0; n < 64; n++) mem[n] = $urandom;
        run_frame("after_reset", 1'b0, 2);
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
